// File: rtl/mrs_pkg.sv
// mrs_pkg: shared states and datapath control codes for mem_read_sequencer
package mrs_pkg;
  typedef enum logic [2:0] {IDLE, FETCH_LO, FETCH_HI, LOAD, DONE} state_e;
  localparam logic [1:0] OUTD_PC     = 2'b00;
  localparam logic [1:0] OUTD_AR     = 2'b10;
  localparam logic [1:0] FUN_INC     = 2'b01;
  localparam logic [2:0] REGSEL_PC   = 3'b100;
  localparam logic [2:0] REGSEL_AR   = 3'b010;
  localparam logic [1:0] DR_LOAD_LSB = 2'b01;
  localparam logic [1:0] DR_SHL_LOAD = 2'b10;
  localparam logic       KIND_FETCH  = 1'b0;
  localparam logic       KIND_LOAD   = 1'b1;
endpackage

// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer: byte-serial IR fetch / DR load engine driving the ALU datapath memory controls
module mem_read_sequencer
  import mrs_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  localparam int LW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_kind,
  input  logic [LW-1:0] req_len,
  output logic          done,
  output logic          Mem_CS,
  output logic          Mem_WR,
  output logic [1:0]    ARF_OutDSel,
  output logic [1:0]    ARF_FunSel,
  output logic [2:0]    ARF_RegSel,
  output logic          IR_Write,
  output logic          IR_LH,
  output logic          DR_E,
  output logic [1:0]    DR_FunSel
);
  state_e state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d, len_q, len_d;
  logic fetch, load;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = (req_kind == KIND_LOAD) ? LOAD : FETCH_LO;
        cnt_d   = req_len;
        len_d   = req_len;
      end
      FETCH_LO: state_d = FETCH_HI;
      FETCH_HI: state_d = DONE;
      LOAD: begin
        state_d = (cnt_q == '0) ? DONE : LOAD;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Controls depend only on registered state, never on req_*.
  assign fetch       = (state_q == FETCH_LO) || (state_q == FETCH_HI);
  assign load        = (state_q == LOAD);
  assign req_ready   = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign Mem_CS      = !(fetch || load);
  assign Mem_WR      = 1'b0;
  assign ARF_OutDSel = load ? OUTD_AR : OUTD_PC;
  assign ARF_FunSel  = (fetch || load) ? FUN_INC : 2'b00;
  assign ARF_RegSel  = fetch ? REGSEL_PC : load ? REGSEL_AR : 3'b000;
  assign IR_Write    = fetch;
  assign IR_LH       = (state_q == FETCH_HI);
  assign DR_E        = load;
  // First byte (cnt still equal to latched len) clears DR; later bytes shift it up.
  assign DR_FunSel   = !load ? 2'b00 : (cnt_q == len_q) ? DR_LOAD_LSB : DR_SHL_LOAD;
endmodule

// File: tb/tb_mem_read_sequencer.sv
// tb_mem_read_sequencer: table-driven + scoreboard bench with a behavioural memory/ARF/IR/DR model
module tb_mem_read_sequencer;
  logic Clock, Reset, req_valid, req_ready, req_kind, done;
  logic [1:0] req_len, ARF_OutDSel, ARF_FunSel, DR_FunSel;
  logic [2:0] ARF_RegSel;
  logic Mem_CS, Mem_WR, IR_Write, IR_LH, DR_E;

  mem_read_sequencer #(.MAX_BYTES(4)) dut (
    .Clock(Clock), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_len(req_len), .done(done), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
    .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_Write(IR_Write), .IR_LH(IR_LH), .DR_E(DR_E), .DR_FunSel(DR_FunSel)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [7:0] mem [0:65535];
  logic [15:0] pc, ar, ir, pre_pc, pre_ar;
  logic [31:0] dr;
  logic pre;
  logic [15:0] addr;
  logic [7:0] rd;
  assign addr = (ARF_OutDSel == 2'b10) ? ar : pc;
  assign rd = mem[addr];

  always @(posedge Clock) begin
    if (pre) begin
      pc <= pre_pc;
      ar <= pre_ar;
      ir <= 16'h0000;
      dr <= 32'hFFFF_FFFF;
    end else begin
      if (ARF_FunSel == 2'b01 && ARF_RegSel[2]) pc <= pc + 16'd1;
      if (ARF_FunSel == 2'b01 && ARF_RegSel[1]) ar <= ar + 16'd1;
      if (IR_Write && IR_LH) ir[15:8] <= rd;
      if (IR_Write && !IR_LH) ir[7:0] <= rd;
      if (DR_E) dr <= (DR_FunSel == 2'b01) ? {24'h0, rd} : (DR_FunSel == 2'b10) ? {dr[23:0], rd} : dr;
    end
  end

  typedef struct {
    logic kind;
    logic [1:0] len;
    logic [15:0] ptr;
    logic [31:0] bytes;
    logic [31:0] val;
    logic [15:0] eptr;
    int lat;
  } vec_t;

  typedef struct {
    logic kind;
    logic [31:0] val;
    logic [15:0] ptr;
    int lat;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int checks = 0, fails = 0, cyc = 0, acc_cyc = 0, ndone = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic acc;
    exp_t e;
    acc = req_valid && req_ready && !Reset;
    @(posedge Clock);
    cyc++;
    if (acc) acc_cyc = cyc;
    @(negedge Clock);
    check("mem_wr_low", {31'h0, Mem_WR}, 32'h0);
    check("cs_vs_enables", {31'h0, Mem_CS}, {31'h0, !(IR_Write || DR_E)});
    if (done) begin
      ndone++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - acc_cyc + 1, e.lat);
        check("data", e.kind ? dr : {16'h0, ir}, e.val);
        check("pointer", {16'h0, e.kind ? ar : pc}, {16'h0, e.ptr});
        check("ready_in_done", {31'h0, req_ready}, 32'h0);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic setup(input vec_t v);
    int nb;
    nb = v.kind ? int'(v.len) + 1 : 2;
    for (int i = 0; i < nb; i++) mem[16'(v.ptr + 16'(i))] = v.bytes[31 - 8*i -: 8];
    pre = 1'b1;
    pre_pc = v.kind ? 16'h0 : v.ptr;
    pre_ar = v.kind ? v.ptr : 16'h0;
    tick();
    pre = 1'b0;
  endtask

  initial begin
    exp_t e;
    int d0;
    vecs[0] = '{1'b0, 2'd0, 16'h0010, 32'h3412_0000, 32'h0000_1234, 16'h0012, 3};
    vecs[1] = '{1'b1, 2'd3, 16'h0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'h0024, 5};
    vecs[2] = '{1'b1, 2'd0, 16'h0030, 32'h5A00_0000, 32'h0000_005A, 16'h0031, 2};
    vecs[3] = '{1'b0, 2'd0, 16'hFFFF, 32'h7856_0000, 32'h0000_5678, 16'h0001, 3};
    vecs[4] = '{1'b1, 2'd1, 16'h0100, 32'h1122_0000, 32'h0000_1122, 16'h0102, 3};
    vecs[5] = '{1'b1, 2'd2, 16'hFFFE, 32'hAABB_CC00, 32'h00AA_BBCC, 16'h0001, 4};
    Reset = 1'b1; req_valid = 1'b0; req_kind = 1'b0; req_len = 2'd0;
    pre = 1'b0; pre_pc = 16'h0; pre_ar = 16'h0;
    tick();
    tick();
    check("reset_outputs", {16'h0, req_ready, done, Mem_CS, Mem_WR, ARF_OutDSel, ARF_FunSel,
          ARF_RegSel, IR_Write, IR_LH, DR_E, DR_FunSel}, 32'h0000_A000);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      setup(vecs[i]);
      req_valid = 1'b1;
      req_kind = vecs[i].kind;
      req_len = vecs[i].len;
      sb.push_back('{vecs[i].kind, vecs[i].val, vecs[i].eptr, vecs[i].lat});
      tick();
      req_valid = 1'b0;
      req_kind = 1'($urandom);
      req_len = 2'($urandom);
      wait_idle();
      tick();
    end

    // back-to-back: req_valid held, fetch then load
    mem[16'h0200] = 8'h0D; mem[16'h0201] = 8'hF0;
    mem[16'h0300] = 8'h12; mem[16'h0301] = 8'h34;
    pre = 1'b1; pre_pc = 16'h0200; pre_ar = 16'h0300;
    tick();
    pre = 1'b0;
    d0 = ndone;
    sb.push_back('{1'b0, 32'h0000_F00D, 16'h0202, 3});
    sb.push_back('{1'b1, 32'h0000_1234, 16'h0302, 3});
    req_valid = 1'b1; req_kind = 1'b0; req_len = 2'd0;
    tick();
    req_kind = 1'b1; req_len = 2'd1;
    for (int k = 0; k < 3; k++) begin
      check("busy_ready_low", {31'h0, req_ready}, 32'h0);
      tick();
    end
    check("idle_ready_high", {31'h0, req_ready}, 32'h1);
    check("idle_cs_high", {31'h0, Mem_CS}, 32'h1);
    tick();
    req_valid = 1'b0;
    wait_idle();
    tick();
    check("b2b_done_count", ndone - d0, 2);

    // reset during the second LOAD cycle of a 4-byte load
    mem[16'h0400] = 8'h01; mem[16'h0401] = 8'h02; mem[16'h0402] = 8'h03; mem[16'h0403] = 8'h04;
    pre = 1'b1; pre_pc = 16'h0; pre_ar = 16'h0400;
    tick();
    pre = 1'b0;
    d0 = ndone;
    req_valid = 1'b1; req_kind = 1'b1; req_len = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    check("second_load_cycle", {30'h0, DR_E, DR_FunSel == 2'b10}, 32'h3);
    Reset = 1'b1;
    tick();
    check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mid_cs", {31'h0, Mem_CS}, 32'h1);
    check("rst_mid_done", {31'h0, done}, 32'h0);
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("rst_mid_no_done", ndone - d0, 0);
    check("rst_mid_stays_idle", {31'h0, req_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_read_sequencer.md
# mem_read_sequencer

Multi-cycle read engine that drives the memory-side control inputs of the ALU datapath system. It carries out two byte-serial transfers over the 8-bit memory port: 16-bit instruction fetch into IR, and 1-4 byte data load into DR. The main control FSM issues one request at a time and gets a one-cycle completion pulse back. All multi-byte sequencing, pointer increments and IR/DR function selection live here, not in the control FSM.

## Interface
Parameters:
- MAX_BYTES, 4, largest data-load length; fixes the width of req_len.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge
- Reset  in  1  synchronous, active-high
- req_valid  in  1  request offered by the control FSM
- req_ready  out  1  high when IDLE; a transfer is accepted when req_valid && req_ready
- req_kind  in  1  0 = instruction fetch via PC, 1 = data load via AR
- req_len  in  2  data-load length minus 1 (0 = 1 byte … 3 = 4 bytes); ignored for fetch
- done  out  1  one-cycle pulse in the cycle after the last byte is written
- Mem_CS  out  1  active-low chip select
- Mem_WR  out  1  held at 0 (read)
- ARF_OutDSel  out  2  00 = PC, 10 = AR
- ARF_FunSel  out  2  01 = increment
- ARF_RegSel  out  3  one-hot {PC, AR, SP}, bit 2 = PC, bit 1 = AR
- IR_Write  out  1  IR load enable
- IR_LH  out  1  0 = low byte, 1 = high byte
- DR_E  out  1  DR enable
- DR_FunSel  out  2  01 = clear and load I into [7:0]; 10 = shift left 8 and load I into [7:0]

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, LOAD, DONE.
- IDLE: req_ready = 1, Mem_CS = 1, and every enable is 0. On acceptance, go to FETCH_LO if req_kind = 0, otherwise go to LOAD with the byte counter cnt = req_len. req_kind and req_len are latched at acceptance.
- FETCH_LO:
  - Mem_CS = 0, ARF_OutDSel = 00, IR_Write = 1, IR_LH = 0.
  - ARF_RegSel = 100 and ARF_FunSel = 01, so PC increments in the same cycle.
  - Next state is FETCH_HI.
- FETCH_HI: same as FETCH_LO but IR_LH = 1. Next state is DONE.
- LOAD:
  - Mem_CS = 0, ARF_OutDSel = 10, DR_E = 1.
  - ARF_RegSel = 010 and ARF_FunSel = 01, so AR increments every byte.
  - DR_FunSel = 01 on the first byte and 10 on later bytes. The first byte read ends up as DR's most significant loaded byte (big-endian assembly).
  - If cnt = 0, go to DONE; otherwise decrement cnt.
- DONE: done = 1, all enables 0, req_ready = 0. Next state is IDLE.
- Any control input not listed for a state is driven 0, except Mem_CS, which is driven 1.
- The transfer ends with the pointer advanced by the number of bytes read: 2 for a fetch, len+1 for a load. PC and AR wrap modulo 2^16 inside the ARF; no special handling here.

## Timing
- Reset values: state IDLE, cnt 0, req_ready 1, done 0, Mem_CS 1, and all other outputs 0.
- MemOut is taken as valid combinationally from the ARF OutD address in the same cycle. IR, DR and the ARF increment all capture on the same edge.
- Latency, counted from the acceptance edge to the done pulse:
  - Fetch: 2 transfer cycles, done in cycle 3.
  - Load: len+1 transfer cycles, done in cycle len+2.
  - Back-to-back throughput is one request every (transfer cycles + 2).
- req_valid while busy is ignored (req_ready = 0). req_kind and req_len may change after acceptance with no effect.
- Reset asserted mid-transfer: return to IDLE on that edge, with no done pulse and outputs at reset values. Partial IR/DR/PC/AR contents are left as written; the datapath Reset clears them anyway.
- No combinational path from req_* to datapath control outputs. Control outputs are a function of state and cnt only.

## Structure
- Shared package mrs_pkg:
  - state enum;
  - ARF codes: OUTD_PC, OUTD_AR, FUN_INC, REGSEL_PC, REGSEL_AR;
  - DR codes: DR_LOAD_LSB, DR_SHL_LOAD;
  - KIND_FETCH, KIND_LOAD.
- Single module; no sub-module. A next-state always block plus a registered state/cnt block. Outputs are decoded from state.

## Test plan
- Fetch: memory [0x0010] = 0x34, [0x0011] = 0x12, PC = 0x0010, req_kind 0 → IR = 0x1234, PC = 0x0012, done in the 3rd cycle after acceptance.
- 4-byte load: AR = 0x0020, memory 0xDE,0xAD,0xBE,0xEF, req_len 3 → DR = 0xDEADBEEF, AR = 0x0024, done in cycle 5.
- 1-byte load: req_len 0, memory [AR] = 0x5A, DR previously 0xFFFFFFFF → DR = 0x0000005A, AR+1, done in cycle 2.
- Wrap: PC = 0xFFFF fetch → bytes read from 0xFFFF then 0x0000, PC = 0x0001.
- Busy/back-to-back: req_valid held high with a fetch followed by a load → second accepted only in IDLE after done; exactly one done per request; Mem_CS high in IDLE/DONE.
- Reset mid-load: assert Reset during the 2nd LOAD cycle of a 4-byte load → next cycle IDLE, req_ready 1, Mem_CS 1, no done pulse.
